mmpu: RTL and testbench
=======================

Name: mmpu

Overview:
- Mini matrix processing unit in the TinyTapeout user-project slot.
- Loads two 2x2 matrices of unsigned 8-bit elements (A, B) one byte at a time and computes C = A x B.
- C elements are saturated to 16 bits; results are read back one byte at a time on uo_out.
- Control arrives on the upper bidirectional pins; status leaves on the lower bidirectional pins.

Parameters:
- none (element width 8, result width 16, matrix size 2x2 are fixed)

Ports:
- clk  in  1  system clock
- rst  in  1  one clock; reset is synchronous and active-high
- ena  in  1  design enable; when 0, commands are ignored and state holds
- ui_in  in  8  load data byte
- uio_in  in  8  [7]=valid, [6:5]=op, [4]=ptr_clr, [3]=reserved (ignored), [2:0] ignored
- uo_out  out  8  result byte at the read pointer
- uio_out  out  8  [0]=busy, [1]=done, [2]=ovf, [7:3]=0
- uio_oe  out  8  constant 8'b0000_0111

Behaviour:
- Storage:
  - 8-entry element file: idx 0-3 = A00,A01,A10,A11; idx 4-7 = B00,B01,B10,B11.
  - 4 result registers C00,C01,C10,C11, 16 bits each.
- Pointers: 3-bit write pointer wp, 3-bit read pointer rp.
- Command acceptance: a command executes on a rising clk edge when rst=0, ena=1, valid=1 and busy=0. Level-sensitive: each qualifying cycle executes once.
- op 00 NOP: no effect.
- op 01 LOAD:
  - elem[wp] <= ui_in; wp <= wp+1, wrapping 7->0.
  - done <= 0 and ovf <= 0.
- op 10 COMPUTE:
  - busy <= 1, element counter k <= 0; rp <= 0.
  - Each following cycle computes one C element (k = 0..3 in order C00,C01,C10,C11): Cij = Ai0*B0j + Ai1*B1j, a 17-bit unsigned intermediate.
  - If the intermediate > 65535, store 16'hFFFF and set ovf.
  - After the 4th element (4 cycles after acceptance): busy <= 0, done <= 1.
- op 11 READ: rp <= rp+1, wrapping 7->0.
- uo_out is combinational from registers:
  - even rp -> C[rp>>1][15:8]; odd rp -> C[rp>>1][7:0].
- ptr_clr=1 with valid=1 and busy=0: wp <= 0 and rp <= 0, in addition to the op.
  - With op 01, the write goes to the pre-clear wp; wp is then 0.
  - With op 11, rp ends at 0.
- While busy=1, all commands, including ptr_clr, are ignored. ena=0 does not pause an in-progress COMPUTE.
- Reset (any cycle, including mid-COMPUTE) clears all of:
  - elements and C registers to 0
  - wp, rp, k to 0
  - busy, done, ovf to 0
  - So uo_out=0 after reset.
- ovf is sticky across the four elements of one COMPUTE. A new COMPUTE clears ovf at acceptance.
- uio_out[7:3]=0 and uio_oe constant in all states, including reset.
- Multipliers: two 8x8 unsigned multipliers plus a 17-bit adder, shared over the 4 cycles.

Test Plan:
- Reset, then LOAD 1,2,3,4,5,6,7,8, then COMPUTE, wait until busy=0:
  - done=1, ovf=0.
  - Eight uo_out reads (READ between samples) give 00,13,00,16,00,2B,00,32 (C=[[19,22],[43,50]]).
  - A 9th read wraps and gives 00 again.
- LOAD eight 0xFF, COMPUTE:
  - All C = FFFF (130050 saturated), ovf=1.
  - Next LOAD clears done and ovf.
- LOAD A=identity (1,0,0,1), B=9,8,7,6, COMPUTE -> C bytes 00,09,00,08,00,07,00,06.
- Issue COMPUTE, then assert LOAD 0x55 and READ on each of the next 3 cycles:
  - Commands ignored, elements unchanged.
  - busy high for exactly 4 cycles after acceptance, then done=1.
- Assert rst on the 2nd busy cycle -> next cycle busy=0, done=0, uo_out=00; wp=0, so the next LOAD writes A00.
- ena=0 with valid=1 op=01 -> no write, wp unchanged.
- Then ptr_clr=1 with op=00 -> wp=rp=0.

Source files
------------

// File: rtl/mmpu.sv
// Mini matrix unit: byte-loads two 2x2 u8 matrices, computes a saturated 16-bit
// C = A x B over four cycles on a shared multiplier pair, and streams C out a byte at a time.
module mmpu (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] OP_LOAD    = 2'b01;
    localparam logic [1:0] OP_COMPUTE = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    state_t      state_reg, state_next;
    logic [7:0]  elem_reg [8];
    logic [15:0] c_reg [4];
    logic [2:0]  wp_reg, wp_next;
    logic [2:0]  rp_reg, rp_next;
    logic [1:0]  k_reg, k_next;
    logic        done_reg, done_next;
    logic        ovf_reg, ovf_next;
    logic [7:0]  elem_we;
    logic [3:0]  c_we;

    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_ptr_clr;
    logic        busy;
    logic        accept;
    logic        unused_bits;

    logic [7:0]  a0, a1, b0, b1;
    logic [15:0] prod0, prod1;
    logic [16:0] sum;
    logic [15:0] sat;

    assign cmd_valid   = uio_in[7];
    assign cmd_op      = uio_in[6:5];
    assign cmd_ptr_clr = uio_in[4];
    assign unused_bits = ^uio_in[3:0];

    assign busy   = (state_reg == RUN);
    assign accept = ena && cmd_valid && !busy;

    // k selects Cij with i = k[1], j = k[0]; operands come straight from the element file.
    assign a0    = elem_reg[{1'b0, k_reg[1], 1'b0}];
    assign a1    = elem_reg[{1'b0, k_reg[1], 1'b1}];
    assign b0    = elem_reg[{2'b10, k_reg[0]}];
    assign b1    = elem_reg[{2'b11, k_reg[0]}];
    assign prod0 = 16'(a0) * 16'(b0);
    assign prod1 = 16'(a1) * 16'(b1);
    assign sum   = 17'(prod0) + 17'(prod1);
    assign sat   = sum[16] ? 16'hFFFF : sum[15:0];

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        wp_next    = wp_reg;
        rp_next    = rp_reg;
        done_next  = done_reg;
        ovf_next   = ovf_reg;
        elem_we    = '0;
        c_we       = '0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            elem_we[wp_reg] = 1'b1;
                            wp_next         = wp_reg + 3'd1;
                            done_next       = 1'b0;
                            ovf_next        = 1'b0;
                        end
                        OP_COMPUTE: begin
                            state_next = RUN;
                            k_next     = 2'd0;
                            rp_next    = 3'd0;
                            done_next  = 1'b0;
                            ovf_next   = 1'b0;
                        end
                        OP_READ: rp_next = rp_reg + 3'd1;
                        default: ;
                    endcase
                    // Pointer clear overrides the op's pointer update; the LOAD write above
                    // still lands at the pre-clear address.
                    if (cmd_ptr_clr) begin
                        wp_next = 3'd0;
                        rp_next = 3'd0;
                    end
                end
            end
            RUN: begin
                c_we[k_reg] = 1'b1;
                if (sum[16]) begin
                    ovf_next = 1'b1;
                end
                k_next = k_reg + 2'd1;
                if (k_reg == 2'd3) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            k_reg     <= 2'd0;
            wp_reg    <= 3'd0;
            rp_reg    <= 3'd0;
            done_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            wp_reg    <= wp_next;
            rp_reg    <= rp_next;
            done_reg  <= done_next;
            ovf_reg   <= ovf_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_elem
            always_ff @(posedge clk) begin
                if (rst) begin
                    elem_reg[gi] <= 8'd0;
                end else if (elem_we[gi]) begin
                    elem_reg[gi] <= ui_in;
                end
            end
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_c
            always_ff @(posedge clk) begin
                if (rst) begin
                    c_reg[gi] <= 16'd0;
                end else if (c_we[gi]) begin
                    c_reg[gi] <= sat;
                end
            end
        end
    endgenerate

    assign uo_out  = rp_reg[0] ? c_reg[rp_reg[2:1]][7:0] : c_reg[rp_reg[2:1]][15:8];
    assign uio_out = {5'b00000, ovf_reg, done_reg, busy};
    assign uio_oe  = 8'b0000_0111;

endmodule

// File: tb/tb_mmpu.sv
// Directed bench for mmpu: stimulus pushes expected bytes into a queue, and a
// negedge monitor pops and compares whenever a sample is presented.
module tb_mmpu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    typedef struct {
        string      name;
        int         kind;   // 0 = uo_out, 1 = uio_out, 2 = uio_oe
        logic [7:0] exp;
    } item_t;

    item_t sb[$];
    logic  sample_en = 1'b0;
    int    total = 0;
    int    bad = 0;

    mmpu dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    // Monitor: one pop and compare per presented sample.
    item_t      mon_it;
    logic [7:0] mon_act;
    always @(negedge clk) begin
        if (sample_en) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty: sample presented with no expectation queued");
            end else begin
                mon_it  = sb.pop_front();
                mon_act = (mon_it.kind == 0) ? uo_out : (mon_it.kind == 1) ? uio_out : uio_oe;
                if (mon_act !== mon_it.exp) begin
                    bad++;
                    $display("FAIL %s: got %02h expected %02h", mon_it.name, mon_act, mon_it.exp);
                end else begin
                    $display("ok   %s: %02h", mon_it.name, mon_act);
                end
            end
        end
    end

    task automatic chk(input string nm, input int kind, input logic [7:0] e);
        item_t it;
        it.name = nm;
        it.kind = kind;
        it.exp  = e;
        sb.push_back(it);
        sample_en = 1'b1;
        @(posedge clk); #1;
        sample_en = 1'b0;
    endtask

    task automatic cmd(input logic [1:0] op, input logic pc, input logic [7:0] d);
        ui_in  = d;
        uio_in = {1'b1, op, pc, 4'b0000};
        @(posedge clk); #1;
        uio_in = 8'h00;
    endtask

    task automatic load4(input logic [7:0] v0, input logic [7:0] v1,
                         input logic [7:0] v2, input logic [7:0] v3);
        cmd(2'b01, 1'b0, v0);
        cmd(2'b01, 1'b0, v1);
        cmd(2'b01, 1'b0, v2);
        cmd(2'b01, 1'b0, v3);
    endtask

    task automatic wait_idle(input string nm);
        bit seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!uio_out[0]) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: busy still %0b after 20 cycles, required 0", nm, uio_out[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic compute_wait(input string nm);
        cmd(2'b10, 1'b0, 8'h00);
        wait_idle(nm);
    endtask

    // Checks the eight result bytes (MSB-first in exp), issuing READ after each.
    task automatic read_bytes(input string nm, input logic [63:0] exp);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_b%0d", nm, i), 0, exp[63-8*i -: 8]);
            cmd(2'b11, 1'b0, 8'h00);
        end
    endtask

    initial begin
        // Reset state, sampled while reset is held.
        @(posedge clk); #1;
        chk("rst_uo_out", 0, 8'h00);
        chk("rst_uio_out", 1, 8'h00);
        chk("rst_uio_oe", 2, 8'h07);
        rst = 1'b0;
        chk("post_rst_uio_oe", 2, 8'h07);

        // C = [[19,22],[43,50]]
        load4(8'd1, 8'd2, 8'd3, 8'd4);
        load4(8'd5, 8'd6, 8'd7, 8'd8);
        compute_wait("basic");
        chk("basic_status", 1, 8'h02);
        read_bytes("basic", 64'h00_13_00_16_00_2B_00_32);
        chk("basic_wrap", 0, 8'h00);

        // Saturation: 2*255*255 = 130050 > 65535
        load4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        load4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        compute_wait("sat");
        chk("sat_status", 1, 8'h06);
        read_bytes("sat", 64'hFF_FF_FF_FF_FF_FF_FF_FF);
        // LOAD with ptr_clr writes elem[0] and clears done/ovf.
        cmd(2'b01, 1'b1, 8'h00);
        chk("load_clears_status", 1, 8'h00);

        // Identity A, B = [[9,8],[7,6]]
        load4(8'd1, 8'd0, 8'd0, 8'd1);
        load4(8'd9, 8'd8, 8'd7, 8'd6);
        compute_wait("ident");
        chk("ident_status", 1, 8'h02);
        read_bytes("ident", 64'h00_09_00_08_00_07_00_06);

        // Commands during busy are ignored; busy lasts exactly four cycles.
        cmd(2'b10, 1'b0, 8'h00);
        for (int c = 1; c <= 4; c++) begin
            ui_in  = 8'h55;
            uio_in = (c == 2) ? 8'hE0 : (c == 4) ? 8'h00 : 8'hA0;
            begin
                item_t it;
                it.name = $sformatf("busy_cycle%0d", c);
                it.kind = 1;
                it.exp  = 8'h01;
                sb.push_back(it);
            end
            sample_en = 1'b1;
            @(posedge clk); #1;
        end
        sample_en = 1'b0;
        uio_in    = 8'h00;
        chk("busy_end_status", 1, 8'h02);
        read_bytes("busy_ign", 64'h00_09_00_08_00_07_00_06);

        // Reset on the second busy cycle; wp moved to 1 beforehand.
        cmd(2'b01, 1'b0, 8'h11);
        cmd(2'b10, 1'b0, 8'h00);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_status", 1, 8'h00);
        chk("midrst_uo_out", 0, 8'h00);
        load4(8'd7, 8'd0, 8'd0, 8'd0);
        cmd(2'b01, 1'b0, 8'd1);              // B00
        ena = 1'b0;
        cmd(2'b01, 1'b0, 8'd9);              // ignored
        ena = 1'b1;
        cmd(2'b01, 1'b0, 8'd2);              // B01
        compute_wait("ena");
        chk("ena_b0", 0, 8'h00);
        cmd(2'b11, 1'b0, 8'h00);
        chk("ena_b1", 0, 8'h07);
        cmd(2'b11, 1'b0, 8'h00);
        chk("ena_b2", 0, 8'h00);
        cmd(2'b11, 1'b0, 8'h00);
        chk("ena_b3", 0, 8'h0E);

        // ptr_clr with NOP clears both pointers.
        cmd(2'b00, 1'b1, 8'h00);
        chk("ptrclr_rp0", 0, 8'h00);
        cmd(2'b11, 1'b0, 8'h00);
        chk("ptrclr_rp1", 0, 8'h07);
        cmd(2'b01, 1'b0, 8'd3);              // must land in A00
        compute_wait("ptrclr");
        read_bytes("ptrclr", 64'h00_03_00_06_00_00_00_00);

        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover: %0d unchecked, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
